// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
// Imported by the interface, the rotating picker and the arbiter top.
package rr_arbiter4_pkg;

  localparam int N_REQ  = 4;
  localparam int IDX_W  = 2;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four request sources and the arbiter.
// The arbiter takes the slave side; the request sources take the master side.
interface rr_arbiter4_if;
  import rr_arbiter4_pkg::*;

  logic              en;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;
  logic [HOLD_W-1:0] hold_cnt;

  modport master (
    output en,
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  hold_cnt
  );

  modport slave (
    input  en,
    input  req,
    output grant,
    output grant_idx,
    output grant_valid,
    output hold_cnt
  );

endinterface

// File: rtl/rr_arbiter4_pick4.sv
// Rotating first-set-bit search: checks req[start], req[start+1], ... mod 4.
// Purely combinational; idx is meaningful only when found is high.
module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate back toward start so the nearest set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = start + IDX_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and an
// optional hold limit that forces rotation when other requesters are waiting.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; next enabled request wins, searching from ptr
//   GRANT | owner holds the resource until release, en low or timeout
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave bus
);

  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  owner;
  logic              valid_q;
  logic [N_REQ-1:0]  grant_q;
  logic [HOLD_W-1:0] hold_q;

  logic [N_REQ-1:0]  pick_req;
  logic [IDX_W-1:0]  pick_start;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  owner_next;
  logic              timeout;
  logic [HOLD_W-1:0] hold_inc;

  assign owner_next = owner + 1'b1;
  assign timeout    = HOLD_EN && (hold_q == HOLD_LAST);
  assign hold_inc   = (hold_q == '1) ? hold_q : hold_q + 1'b1;

  // While granted, the owner is masked out and searched last.
  always_comb begin
    if (state == GRANT) begin
      pick_req   = bus.req & ~onehot(owner);
      pick_start = owner_next;
    end else begin
      pick_req   = bus.req;
      pick_start = ptr;
    end
  end

  rr_pick4 u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      hold_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en && pick_found) begin
            state   <= GRANT;
            owner   <= pick_idx;
            valid_q <= 1'b1;
            grant_q <= onehot(pick_idx);
            hold_q  <= '0;
          end
        end

        GRANT: begin
          if (!bus.en) begin
            state   <= IDLE;
            ptr     <= owner_next;
            owner   <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            hold_q  <= '0;
          end else if (!bus.req[owner]) begin
            ptr <= owner_next;
            if (pick_found) begin
              owner   <= pick_idx;
              grant_q <= onehot(pick_idx);
              hold_q  <= '0;
            end else begin
              state   <= IDLE;
              owner   <= '0;
              valid_q <= 1'b0;
              grant_q <= '0;
              hold_q  <= '0;
            end
          end else if (timeout) begin
            // With nobody waiting the owner simply starts a fresh hold window.
            if (pick_found) begin
              ptr     <= owner_next;
              owner   <= pick_idx;
              grant_q <= onehot(pick_idx);
            end
            hold_q <= '0;
          end else begin
            hold_q <= hold_inc;
          end
        end

        default: begin
          state   <= IDLE;
          owner   <= '0;
          valid_q <= 1'b0;
          grant_q <= '0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = owner;
  assign bus.grant_valid = valid_q;
  assign bus.hold_cnt    = hold_q;

endmodule
